// File: rtl/afifo_rd_burst_engine.sv
// rtl/afifo_rd_burst_engine.sv - read-domain burst engine for the async FIFO
// Pops up to cmd_len words, streams them over a one-deep valid/ready slot and
// reports completion status plus a saturating empty-event counter.
module afifo_rd_burst_engine #(
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_nb,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_last,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  done_count,
  output logic [1:0]            done_status,
  output logic [STAT_WIDTH-1:0] stat_empty_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ABORT   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ZERO    = 2'd3;

  // tmo only has to reach TIMEOUT_CYCLES-1; the timeout exit fires there
  localparam int TMO_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_nxt;
  logic [1:0]            status_q, status_nxt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  nb_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [TMO_WIDTH-1:0]  tmo_q;
  logic [LEN_WIDTH-1:0]  done_count_q;
  logic [1:0]            done_status_q;

  logic slot_free;
  logic cmd_fire;
  logic last_pop;
  logic empty_evt;

  assign slot_free = !dout_valid || dout_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign last_pop  = rinc && (cnt_q == len_q - LEN_WIDTH'(1));
  // an empty READ cycle ends the command either immediately (nb) or at the timeout limit
  assign empty_evt = (state_q == S_READ) && rempty && (nb_q || (tmo_q == TMO_LAST));

  // State and pending-status register
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_nxt;
      status_q <= status_nxt;
    end
  end

  // Next-state and completion-status selection
  always_comb begin
    state_nxt  = state_q;
    status_nxt = status_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            state_nxt  = S_DONE;
            status_nxt = ST_ZERO;
          end else begin
            state_nxt  = S_READ;
          end
        end
      end
      S_READ: begin
        // a pop and an empty flag are mutually exclusive, so the pop always wins
        if (last_pop) begin
          state_nxt  = S_DONE;
          status_nxt = ST_OK;
        end else if (rempty && nb_q) begin
          state_nxt  = S_DONE;
          status_nxt = ST_ABORT;
        end else if (rempty && (tmo_q == TMO_LAST)) begin
          state_nxt  = S_DONE;
          status_nxt = ST_TIMEOUT;
        end
      end
      S_DONE: begin
        if (slot_free) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM-decoded strobes
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    rinc      = (state_q == S_READ) && !rempty && slot_free;
    done      = (state_q == S_DONE) && slot_free;
  end

  // Command latch, word counter and empty-cycle timer
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      len_q <= '0;
      nb_q  <= 1'b0;
      cnt_q <= '0;
      tmo_q <= '0;
    end else if (cmd_fire) begin
      len_q <= cmd_len;
      nb_q  <= cmd_nb;
      cnt_q <= '0;
      tmo_q <= '0;
    end else if (rinc) begin
      cnt_q <= cnt_q + LEN_WIDTH'(1);
      tmo_q <= '0;
    end else if ((state_q == S_READ) && rempty && !nb_q && (tmo_q != TMO_LAST)) begin
      tmo_q <= tmo_q + TMO_WIDTH'(1);
    end
  end

  // Single-register output slot
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_last  <= 1'b0;
    end else if (rinc) begin
      dout_valid <= 1'b1;
      dout_data  <= rdata;
      dout_last  <= (cnt_q == len_q - LEN_WIDTH'(1));
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end
  end

  // Hold the reported count/status from one done pulse to the next
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      done_count_q  <= '0;
      done_status_q <= ST_OK;
    end else if (done) begin
      done_count_q  <= cnt_q;
      done_status_q <= status_q;
    end
  end

  // Saturating count of abort and timeout events
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      stat_empty_cnt <= '0;
    end else if (empty_evt && (stat_empty_cnt != '1)) begin
      stat_empty_cnt <= stat_empty_cnt + STAT_WIDTH'(1);
    end
  end

  assign done_count  = done ? cnt_q    : done_count_q;
  assign done_status = done ? status_q : done_status_q;

endmodule
